mult_unit: RTL and testbench

//  Multi-cycle unsigned shift-add multiplier for MUL (low WORD bits of Rn*Rm); execute-stage consumer of decode.

---
 rtl/mult_unit_pkg.sv | 13 +
 rtl/mult_unit_step.sv | 22 ++
 rtl/mult_unit.sv | 108 ++++++++++
 tb/tb_mult_unit.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/mult_unit_pkg.sv
// Shared constants and state encoding for the shift-add multiplier.
// Optional build macro: MULT_EARLY_EXIT_EN (see mult_unit.sv).
package mult_unit_pkg;

    localparam int DEFAULT_WORD = 64;

    typedef enum logic [1:0] {
        MULT_IDLE = 2'b00,
        MULT_RUN  = 2'b01,
        MULT_DONE = 2'b10
    } mult_state_e;

endpackage

// File: rtl/mult_unit_step.sv
// One shift-add step: adds mcand << i to the accumulator for every set bit i
// of the multiplier slice. Purely combinational, wraps modulo 2^WORD.
module mult_unit_step #(
    parameter int WORD = 64,
    parameter int BPC  = 1
) (
    input  logic [WORD-1:0] acc,
    input  logic [WORD-1:0] mcand,
    input  logic [BPC-1:0]  mplier_slice,
    output logic [WORD-1:0] acc_next
);

    always_comb begin
        acc_next = acc;
        for (int i = 0; i < BPC; i++) begin
            if (mplier_slice[i]) begin
                acc_next = acc_next + (mcand << i);
            end
        end
    end

endmodule

// File: rtl/mult_unit.sv
// Multi-cycle unsigned shift-add multiplier returning the low WORD bits of the product.
// Build macro MULT_EARLY_EXIT_EN: finish as soon as the remaining multiplier bits are all zero.
module mult_unit
    import mult_unit_pkg::*;
#(
    parameter int WORD           = DEFAULT_WORD,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [WORD-1:0] multiplicand,
    input  logic [WORD-1:0] multiplier,
    output logic            busy,
    output logic            done,
    output logic [WORD-1:0] result
);

    localparam int N  = WORD / BITS_PER_CYCLE;
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(N - 1);

    mult_state_e     state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [WORD-1:0] mcand_q, mcand_d;
    logic [WORD-1:0] mplier_q, mplier_d;
    logic [WORD-1:0] acc_q, acc_d;
    logic [WORD-1:0] result_q, result_d;
    logic [WORD-1:0] acc_step;
    logic [WORD-1:0] mplier_shift;
    logic            last_step;

    mult_unit_step #(
        .WORD (WORD),
        .BPC  (BITS_PER_CYCLE)
    ) u_step (
        .acc          (acc_q),
        .mcand        (mcand_q),
        .mplier_slice (mplier_q[BITS_PER_CYCLE-1:0]),
        .acc_next     (acc_step)
    );

    assign mplier_shift = mplier_q >> BITS_PER_CYCLE;

`ifdef MULT_EARLY_EXIT_EN
    // Nothing left to add once the unretired multiplier bits are all zero.
    assign last_step = (cnt_q == LAST_CNT) || (mplier_shift == '0);
`else
    assign last_step = (cnt_q == LAST_CNT);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            MULT_IDLE, MULT_DONE: begin
                if (start) begin
                    state_d  = MULT_RUN;
                    mcand_d  = multiplicand;
                    mplier_d = multiplier;
                    acc_d    = '0;
                    cnt_d    = '0;
                end else begin
                    state_d = MULT_IDLE;
                end
            end
            MULT_RUN: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << BITS_PER_CYCLE;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + 1'b1;
                if (last_step) begin
                    state_d  = MULT_DONE;
                    result_d = acc_step;
                end
            end
            default: state_d = MULT_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= MULT_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // DONE lasts exactly one cycle, so done is a single-cycle pulse.
    assign busy   = (state_q == MULT_RUN);
    assign done   = (state_q == MULT_DONE);
    assign result = result_q;

endmodule

// File: tb/tb_mult_unit.sv
// Self-checking bench for mult_unit: BPC=1 and BPC=4 instances, vector table plus
// hand-written sequences for ignored start, mid-run reset and back-to-back starts.
module tb_mult_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start0, start1;
    logic [63:0] a0, b0, a1, b1;
    logic        busy0, done0, busy1, done1;
    logic [63:0] res0, res1;

    always #5 clk = ~clk;

    mult_unit #(.WORD(64), .BITS_PER_CYCLE(1)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .multiplicand(a0), .multiplier(b0),
        .busy(busy0), .done(done0), .result(res0)
    );

    mult_unit #(.WORD(64), .BITS_PER_CYCLE(4)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .multiplicand(a1), .multiplier(b1),
        .busy(busy1), .done(done1), .result(res1)
    );

    typedef struct {
        logic [63:0] r;
        int          lat;
        int          sel;
    } exp_t;

    typedef struct {
        int          sel;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] r;
    } vec_t;

    localparam int NV = 12;

    exp_t sb[$];
    vec_t vt[NV];
    int   n_vec = 0;
    int   n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic int exp_lat(input logic [63:0] b, input int bpc);
        int msb;
        msb = -1;
        for (int i = 0; i < 64; i++) if (b[i]) msb = i;
`ifdef MULT_EARLY_EXIT_EN
        if (msb < 0) return 1;
        return (msb + bpc) / bpc;
`else
        if (msb < -1) return 0;
        return 64 / bpc;
`endif
    endfunction

    function automatic logic dn(input int sel);
        return (sel != 0) ? done1 : done0;
    endfunction

    function automatic logic bs(input int sel);
        return (sel != 0) ? busy1 : busy0;
    endfunction

    function automatic logic [63:0] rs(input int sel);
        return (sel != 0) ? res1 : res0;
    endfunction

    // Called on a negedge; drives start for one edge and returns one negedge later.
    task automatic launch(input int sel, input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] r);
        exp_t e;
        e.r   = r;
        e.lat = exp_lat(b, (sel != 0) ? 4 : 1);
        e.sel = sel;
        sb.push_back(e);
        if (sel != 0) begin
            start1 = 1'b1; a1 = a; b1 = b;
        end else begin
            start0 = 1'b1; a0 = a; b0 = b;
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        if (sel != 0) begin
            a1 = {$urandom, $urandom}; b1 = {$urandom, $urandom};
        end else begin
            a0 = {$urandom, $urandom}; b0 = {$urandom, $urandom};
        end
    endtask

    // pre = negedges already consumed since launch returned.
    task automatic collect(input int pre);
        exp_t e;
        int   bc;
        int   t;
        e  = sb.pop_front();
        bc = pre;
        t  = 0;
        while (!dn(e.sel) && t < 300) begin
            if (bs(e.sel)) bc++;
            t++;
            @(negedge clk);
        end
        check("done_seen", 64'(dn(e.sel)), 64'd1);
        check("result", rs(e.sel), e.r);
        check("latency", 64'(bc), 64'(e.lat));
        check("busy_at_done", 64'(bs(e.sel)), 64'd0);
    endtask

    initial begin
        int k;
        bit seen;
        reset  = 1'b0;
        start0 = 1'b0; start1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;

        vt[0]  = '{0, 64'h3, 64'h5, 64'hF};
        vt[1]  = '{0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h2, 64'hFFFF_FFFF_FFFF_FFFE};
        vt[2]  = '{0, 64'h0, 64'h12345, 64'h0};
        vt[3]  = '{0, 64'h12345, 64'h0, 64'h0};
        vt[4]  = '{0, 64'hFFFF_FFFF, 64'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001};
        vt[5]  = '{0, 64'h8000_0000_0000_0000, 64'h3, 64'h8000_0000_0000_0000};
        vt[6]  = '{0, 64'hABC, 64'h1, 64'hABC};
        vt[7]  = '{0, 64'h5, 64'h80, 64'h280};
        vt[8]  = '{1, 64'h1234, 64'h10, 64'h12340};
        vt[9]  = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1};
        vt[10] = '{1, 64'hDEAD_BEEF, 64'h100, 64'hDE_ADBE_EF00};
        vt[11] = '{1, 64'h5, 64'h0, 64'h0};

        repeat (3) @(negedge clk);
        check("rst_busy0", 64'(busy0), 64'd0);
        check("rst_done0", 64'(done0), 64'd0);
        check("rst_result0", res0, 64'd0);
        check("rst_busy1", 64'(busy1), 64'd0);
        check("rst_done1", 64'(done1), 64'd0);
        check("rst_result1", res1, 64'd0);
        reset = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            launch(vt[i].sel, vt[i].a, vt[i].b, vt[i].r);
            collect(0);
            @(negedge clk);
            check("done_pulse", 64'(dn(vt[i].sel)), 64'd0);
            check("result_hold", rs(vt[i].sel), vt[i].r);
        end

        // start pulsed while running must not disturb the product in flight
        launch(0, 64'd7, 64'd9, 64'd63);
        k = (exp_lat(64'd9, 1) >= 12) ? 9 : 1;
        repeat (k) @(negedge clk);
        start0 = 1'b1; a0 = 64'd100; b0 = 64'd100;
        @(negedge clk);
        start0 = 1'b0;
        collect(k + 1);
        @(negedge clk);

        // asynchronous reset in the middle of a run
        start0 = 1'b1; a0 = 64'd3; b0 = 64'h8000_0000_0000_0000;
        @(negedge clk);
        start0 = 1'b0;
        repeat (19) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_busy", 64'(busy0), 64'd0);
        check("abort_done", 64'(done0), 64'd0);
        check("abort_result", res0, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        seen = 1'b0;
        repeat (80) begin
            @(negedge clk);
            if (done0) seen = 1'b1;
        end
        check("abort_no_done", 64'(seen), 64'd0);
        launch(0, 64'd2, 64'd2, 64'd4);
        collect(0);
        @(negedge clk);

        // back-to-back: restart on the done cycle
        launch(1, 64'h1234, 64'h10, 64'h12340);
        collect(0);
        launch(1, 64'h11, 64'h11, 64'h121);
        check("b2b_busy", 64'(busy1), 64'd1);
        check("b2b_done", 64'(done1), 64'd0);
        check("b2b_hold", res1, 64'h12340);
        collect(0);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
